// File: rtl/program_loader_if.sv
// Byte-stream receive handshake and program-memory write port of the program loader.
// The master modport is the loader side; the slave modport is the byte source / memory side.
interface program_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        mem_write_enable;
    logic [31:0] mem_byte_address;
    logic [31:0] mem_write_data;

    modport master (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output mem_write_enable,
        output mem_byte_address,
        output mem_write_data
    );

    modport slave (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  mem_write_enable,
        input  mem_byte_address,
        input  mem_write_data
    );
endinterface

// File: rtl/program_loader.sv
// Loads a length-prefixed little-endian byte stream into program memory as 32-bit words,
// holding the core in reset until the image is complete.
module program_loader #(
    parameter int          MEM_WORDS      = 256,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load_req,
    program_loader_if.master      bus,
    output logic                  cpu_reset_n,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           words_loaded
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    localparam logic [31:0] MEM_WORDS_W  = 32'(MEM_WORDS);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state_r;
    logic [31:0] shift_r;
    logic [31:0] word_count_r;
    logic [1:0]  byte_cnt_r;
    logic [31:0] index_r;
    logic [31:0] idle_cnt_r;

    logic        xfer_s;
    logic        last_byte_s;
    logic        timeout_s;
    logic [31:0] assembled_s;
    logic [31:0] index_next_s;

    // Handshake decode and little-endian word assembly (new byte enters at the top).
    assign xfer_s       = bus.rx_valid && bus.rx_ready;
    assign last_byte_s  = (byte_cnt_r == 2'd3);
    assign timeout_s    = (idle_cnt_r == TIMEOUT_LAST);
    assign assembled_s  = {bus.rx_data, shift_r[31:8]};
    assign index_next_s = index_r + 32'd1;

    // Loader FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r              <= ST_IDLE;
            shift_r              <= 32'd0;
            word_count_r         <= 32'd0;
            byte_cnt_r           <= 2'd0;
            index_r              <= 32'd0;
            idle_cnt_r           <= 32'd0;
            bus.rx_ready         <= 1'b0;
            bus.mem_write_enable <= 1'b0;
            bus.mem_byte_address <= 32'd0;
            bus.mem_write_data   <= 32'd0;
            cpu_reset_n          <= 1'b0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            error                <= 1'b0;
            words_loaded         <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (load_req) begin
                        state_r      <= ST_LEN;
                        bus.rx_ready <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= 16'd0;
                        cpu_reset_n  <= 1'b0;
                        byte_cnt_r   <= 2'd0;
                        idle_cnt_r   <= 32'd0;
                    end else begin
                        // A failed image must never be executed.
                        cpu_reset_n <= (state_r != ST_ERROR);
                    end
                end
                ST_LEN: begin
                    if (xfer_s) begin
                        shift_r    <= assembled_s;
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        idle_cnt_r <= 32'd0;
                        if (last_byte_s) begin
                            word_count_r <= assembled_s;
                            if (assembled_s == 32'd0) begin
                                state_r      <= ST_DONE;
                                bus.rx_ready <= 1'b0;
                                busy         <= 1'b0;
                                done         <= 1'b1;
                            end else if (assembled_s > MEM_WORDS_W) begin
                                state_r      <= ST_ERROR;
                                bus.rx_ready <= 1'b0;
                                busy         <= 1'b0;
                                error        <= 1'b1;
                            end else begin
                                state_r <= ST_DATA;
                                index_r <= 32'd0;
                            end
                        end
                    end else if (timeout_s) begin
                        state_r      <= ST_ERROR;
                        bus.rx_ready <= 1'b0;
                        busy         <= 1'b0;
                        error        <= 1'b1;
                    end else begin
                        idle_cnt_r <= idle_cnt_r + 32'd1;
                    end
                end
                ST_DATA: begin
                    if (xfer_s) begin
                        shift_r    <= assembled_s;
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        idle_cnt_r <= 32'd0;
                        if (last_byte_s) begin
                            state_r              <= ST_WRITE;
                            bus.rx_ready         <= 1'b0;
                            bus.mem_write_enable <= 1'b1;
                            bus.mem_byte_address <= BASE_ADDR + (index_r << 2);
                            bus.mem_write_data   <= assembled_s;
                        end
                    end else if (timeout_s) begin
                        state_r      <= ST_ERROR;
                        bus.rx_ready <= 1'b0;
                        busy         <= 1'b0;
                        error        <= 1'b1;
                    end else begin
                        idle_cnt_r <= idle_cnt_r + 32'd1;
                    end
                end
                ST_WRITE: begin
                    bus.mem_write_enable <= 1'b0;
                    index_r              <= index_next_s;
                    words_loaded         <= words_loaded + 16'd1;
                    if (index_next_s == word_count_r) begin
                        state_r <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        state_r      <= ST_DATA;
                        bus.rx_ready <= 1'b1;
                        idle_cnt_r   <= 32'd0;
                    end
                end
                default: begin
                    state_r              <= ST_IDLE;
                    bus.rx_ready         <= 1'b0;
                    bus.mem_write_enable <= 1'b0;
                    busy                 <= 1'b0;
                end
            endcase
        end
    end

endmodule
